// File: rtl/softmax_div_issue_if.sv
// Bundle of the stream, divider and result signals around softmax_div_issue.
// slave is the normaliser's view; master is the view of whatever surrounds it
// (exp() producer, 40/32 divider and probability consumer together).
interface softmax_div_issue_if #(
    parameter int EXP_W      = 32,
    parameter int DIV_A_W    = 40,
    parameter int FRAC_SHIFT = 8
);
    // exp() value stream in
    logic                  in_valid;
    logic                  in_ready;
    logic [EXP_W-1:0]      in_data;
    logic                  in_last;
    // divider operands out, divider result back
    logic [DIV_A_W-1:0]    div_a;
    logic [EXP_W-1:0]      div_b;
    logic [DIV_A_W-1:0]    div_quotient;
    logic                  div_by_0;
    // probability stream out plus sticky status
    logic                  out_valid;
    logic [FRAC_SHIFT:0]   out_data;
    logic                  out_last;
    logic                  status_ovf;
    logic                  status_div0;

    modport slave (
        input  in_valid, in_data, in_last, div_quotient, div_by_0,
        output in_ready, div_a, div_b, out_valid, out_data, out_last,
               status_ovf, status_div0
    );

    modport master (
        output in_valid, in_data, in_last, div_quotient, div_by_0,
        input  in_ready, div_a, div_b, out_valid, out_data, out_last,
               status_ovf, status_div0
    );
endinterface

// File: rtl/softmax_div_issue.sv
// Softmax front-end: buffers one vector of exp() values, sums it, then feeds value<<FRAC_SHIFT / sum to a fixed-latency divider.
// Latency: issue cycle k -> div_a at k+1 -> out_valid at k+DIV_LAT+2; outputs of one vector are back-to-back.
// Backpressure: in_ready low while issuing/draining; no backpressure on the output side (divider cannot stall).
//
// Ports: clk, rst_n (async active-low) plus bus (softmax_div_issue_if.slave):
//   in_valid/in_ready/in_data/in_last  exp() value stream
//   div_a/div_b -> divider, div_quotient/div_by_0 <- divider
//   out_valid/out_data/out_last        Q1.FRAC_SHIFT probabilities
//   status_ovf/status_div0             sticky truncation / zero-sum flags
// Optional build macro SOFTMAX_ROUND_EN: biases the dividend by sum/2 so the quotient rounds to nearest.
module softmax_div_issue #(
    parameter int EXP_W      = 32,
    parameter int DIV_A_W    = 40,
    parameter int FRAC_SHIFT = 8,
    parameter int VEC_MAX    = 64,
    parameter int DIV_LAT    = 63
) (
    input logic               clk,
    input logic               rst_n,
    softmax_div_issue_if.slave bus
);
    localparam int PTR_W = $clog2(VEC_MAX);
    localparam int CNT_W = PTR_W + 1;
    localparam int AW1   = DIV_A_W + 1;
    // 1.0 in Q1.FRAC_SHIFT, the ceiling for any probability
    localparam logic [DIV_A_W-1:0] PROB_ONE = DIV_A_W'(1) << FRAC_SHIFT;

    typedef enum logic [1:0] {ACCUM, ISSUE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [EXP_W-1:0]    buf_mem [VEC_MAX];
    logic [CNT_W-1:0]    count;
    logic [EXP_W-1:0]    sum;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DIV_A_W-1:0]  div_a;
    logic [EXP_W-1:0]    div_b;
    // token delay line: index i holds the token issued i+1 cycles ago
    logic [DIV_LAT:0]    tok_vld;
    logic [DIV_LAT:0]    tok_last;
    logic                out_valid;
    logic [FRAC_SHIFT:0] out_data;
    logic                out_last;
    logic                status_ovf;
    logic                status_div0;

    logic                in_ready;
    logic                issue_en;
    logic                drain_done;
    logic                accept;
    logic                at_cap;
    logic                last_issue;
    logic                line_empty;
    logic [EXP_W:0]      sum_add;
    logic [EXP_W-1:0]    sum_sat;
    logic [EXP_W-1:0]    rd_data;
    logic [DIV_A_W-1:0]  div_a_nxt;

    assign accept     = bus.in_valid && in_ready;
    // element being accepted is the VEC_MAX-th one: vector is closed here regardless of in_last
    assign at_cap     = (count == CNT_W'(VEC_MAX - 1));
    assign last_issue = ({1'b0, rd_ptr} == (count - CNT_W'(1)));
    assign line_empty = ~|tok_vld;

    assign sum_add = {1'b0, sum} + {1'b0, bus.in_data};
    assign sum_sat = sum_add[EXP_W] ? {EXP_W{1'b1}} : sum_add[EXP_W-1:0];

    assign rd_data = buf_mem[rd_ptr];

`ifdef SOFTMAX_ROUND_EN
    // adding sum/2 before the truncating divide gives round-to-nearest;
    // the top dividends can overflow DIV_A_W, so clamp
    logic [AW1-1:0] a_rnd;
    assign a_rnd     = {1'b0, rd_data, {FRAC_SHIFT{1'b0}}} + AW1'(sum >> 1);
    assign div_a_nxt = a_rnd[DIV_A_W] ? {DIV_A_W{1'b1}} : a_rnd[DIV_A_W-1:0];
`else
    assign div_a_nxt = {rd_data, {FRAC_SHIFT{1'b0}}};
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && (bus.in_last || at_cap)) state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (line_empty) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready   = 1'b0;
        issue_en   = 1'b0;
        drain_done = 1'b0;
        case (state)
            ACCUM:   in_ready   = 1'b1;
            ISSUE:   issue_en   = 1'b1;
            DRAIN:   drain_done = line_empty;
            default: ;
        endcase
    end

    // Element storage; count never reaches VEC_MAX while in ACCUM, so the index fits.
    always_ff @(posedge clk) begin
        if (accept) buf_mem[count[PTR_W-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            sum         <= '0;
            rd_ptr      <= '0;
            div_a       <= '0;
            div_b       <= '0;
            tok_vld     <= '0;
            tok_last    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            status_ovf  <= 1'b0;
            status_div0 <= 1'b0;
        end else begin
            tok_vld  <= {tok_vld[DIV_LAT-1:0], issue_en};
            tok_last <= {tok_last[DIV_LAT-1:0], issue_en && last_issue};

            if (accept) begin
                count <= count + CNT_W'(1);
                sum   <= sum_sat;
                if (at_cap && !bus.in_last) status_ovf <= 1'b1;
            end

            // div_a/div_b only move while issuing, otherwise they hold
            if (issue_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                div_a  <= div_a_nxt;
                div_b  <= sum;
            end

            if (drain_done) begin
                count  <= '0;
                sum    <= '0;
                rd_ptr <= '0;
            end

            // token leaving the line is aligned with its quotient
            out_valid <= tok_vld[DIV_LAT];
            out_last  <= tok_vld[DIV_LAT] && tok_last[DIV_LAT];
            if (tok_vld[DIV_LAT]) begin
                if (bus.div_by_0) begin
                    out_data    <= '0;
                    status_div0 <= 1'b1;
                end else if (bus.div_quotient > PROB_ONE) begin
                    out_data <= PROB_ONE[FRAC_SHIFT:0];
                end else begin
                    out_data <= bus.div_quotient[FRAC_SHIFT:0];
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.div_a       = div_a;
    assign bus.div_b       = div_b;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_last    = out_last;
    assign bus.status_ovf  = status_ovf;
    assign bus.status_div0 = status_div0;
endmodule

// File: tb/tb_softmax_div_issue.sv
// Bench for softmax_div_issue: drives exp() vectors, models the 40/32 divider as a
// DIV_LAT-deep pipeline, and checks probabilities against a scoreboard queue.
module tb_softmax_div_issue;
    localparam int DIV_LAT = 63;

    typedef struct packed {
        logic [8:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    softmax_div_issue_if bus ();

    softmax_div_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // divider model: quotient for the operands present in cycle m appears in cycle m+DIV_LAT
    logic [39:0] q_pipe [DIV_LAT];
    logic        z_pipe [DIV_LAT];
    always @(posedge clk) begin
        q_pipe[0] <= (bus.div_b == 32'd0) ? 40'hFF_FFFF_FFFF : bus.div_a / {8'd0, bus.div_b};
        z_pipe[0] <= (bus.div_b == 32'd0);
        for (int i = 1; i < DIV_LAT; i++) begin
            q_pipe[i] <= q_pipe[i-1];
            z_pipe[i] <= z_pipe[i-1];
        end
    end
    assign bus.div_quotient = q_pipe[DIV_LAT-1];
    assign bus.div_by_0     = z_pipe[DIV_LAT-1];

    // expected probability of x within a vector summing to s
    function automatic logic [8:0] ref_prob(input logic [31:0] x, input logic [31:0] s);
        logic [40:0] a;
        logic [40:0] q;
        if (s == 32'd0) return 9'd0;
        a = {9'd0, x} << 8;
`ifdef SOFTMAX_ROUND_EN
        a = a + {9'd0, s >> 1};
        if (a > 41'h0FF_FFFF_FFFF) a = 41'h0FF_FFFF_FFFF;
`endif
        q = a / {9'd0, s};
        return (q > 41'd256) ? 9'd256 : q[8:0];
    endfunction

    // output monitor: every probability is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got data=%0d last=%0b, required no output", bus.out_data, bus.out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    n_err++;
                    $display("FAIL prob_out @%0d: got data=%0d last=%0b, required data=%0d last=%0b",
                             cyc, bus.out_data, bus.out_last, e.data, e.last);
                end
            end
        end
    end

    // Drive one vector (expected results queued first). Returns at the negedge after the
    // final accept; lat = cycles from there (ISSUE entry) to first out_valid, -1 if no output appears.
    task automatic send_vector(input logic [31:0] vals[$], input bit with_last, input bit wait_out,
                               output int lat);
        logic [63:0] s;
        int          issue_cyc;
        s = 64'd0;
        foreach (vals[i]) s += {32'd0, vals[i]};
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
        foreach (vals[i]) sb.push_back('{ref_prob(vals[i], s[31:0]), (i == vals.size() - 1)});
        for (int i = 0; i < vals.size(); i++) begin
            for (int w = 0; w < 300 && !bus.in_ready; w++) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            bus.in_last  = with_last && (i == vals.size() - 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 32'd0;
        issue_cyc = cyc;
        lat = -1;
        if (wait_out) begin
            for (int w = 0; w < 200; w++) begin
                if (bus.out_valid) begin
                    lat = cyc - issue_cyc;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(output bit tmo);
        tmo = 1'b1;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b, required 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b, required 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 9'd0) begin n_err++; $display("FAIL rst_out_data: got %0d, required 0", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %0b, required 0", bus.out_last); end
        n_cmp++; if (bus.div_a !== 40'd0) begin n_err++; $display("FAIL rst_div_a: got %0h, required 0", bus.div_a); end
        n_cmp++; if (bus.div_b !== 32'd0) begin n_err++; $display("FAIL rst_div_b: got %0h, required 0", bus.div_b); end
        n_cmp++; if (bus.status_ovf !== 1'b0) begin n_err++; $display("FAIL rst_status_ovf: got %0b, required 0", bus.status_ovf); end
        n_cmp++; if (bus.status_div0 !== 1'b0) begin n_err++; $display("FAIL rst_status_div0: got %0b, required 0", bus.status_div0); end
    endtask

    task automatic test_basic;
        logic [31:0] v[$];
        int lat;
        bit tmo;
        v.push_back(32'd256); v.push_back(32'd256); v.push_back(32'd512); v.push_back(32'd1024);
        send_vector(v, 1'b1, 1'b1, lat);
        n_cmp++; if (lat != 65) begin n_err++; $display("FAIL basic_latency: got %0d, required 65", lat); end
        wait_idle(tmo);
        n_cmp++; if (tmo) begin n_err++; $display("FAIL basic_drain: in_ready got 0, required 1 within bound"); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL basic_count: %0d outputs missing, required 0", sb.size()); end
    endtask

    task automatic test_small;
        logic [31:0] v[$];
        int lat;
        bit tmo;
        v.push_back(32'd1); v.push_back(32'd2);
        send_vector(v, 1'b1, 1'b1, lat);
        wait_idle(tmo);
        n_cmp++; if (tmo || sb.size() != 0) begin n_err++; $display("FAIL pair_drain: tmo=%0b left=%0d, required 0/0", tmo, sb.size()); end
        v.delete();
        v.push_back(32'd7);
        send_vector(v, 1'b1, 1'b1, lat);
        n_cmp++; if (lat != 65) begin n_err++; $display("FAIL single_latency: got %0d, required 65", lat); end
        wait_idle(tmo);
        n_cmp++; if (tmo || sb.size() != 0) begin n_err++; $display("FAIL single_drain: tmo=%0b left=%0d, required 0/0", tmo, sb.size()); end
    endtask

    task automatic test_zero_sum;
        logic [31:0] v[$];
        int lat;
        bit tmo;
        n_cmp++; if (bus.status_div0 !== 1'b0) begin n_err++; $display("FAIL div0_before: got %0b, required 0", bus.status_div0); end
        v.push_back(32'd0); v.push_back(32'd0); v.push_back(32'd0);
        send_vector(v, 1'b1, 1'b1, lat);
        wait_idle(tmo);
        n_cmp++; if (tmo) begin n_err++; $display("FAIL div0_drain: in_ready got 0, required 1 within bound"); end
        n_cmp++; if (bus.status_div0 !== 1'b1) begin n_err++; $display("FAIL div0_sticky: got %0b, required 1", bus.status_div0); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL div0_count: %0d outputs missing, required 0", sb.size()); end
    endtask

    task automatic test_overflow;
        logic [31:0] v[$];
        int lat;
        bit tmo;
        n_cmp++; if (bus.status_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before: got %0b, required 0", bus.status_ovf); end
        for (int i = 0; i < 64; i++) v.push_back(32'(i + 1));
        send_vector(v, 1'b0, 1'b1, lat);
        n_cmp++; if (bus.status_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b, required 1", bus.status_ovf); end
        n_cmp++; if (lat != 65) begin n_err++; $display("FAIL ovf_latency: got %0d, required 65", lat); end
        // 65th element opens the next vector; it waits on in_ready inside send_vector
        v.delete();
        v.push_back(32'd65); v.push_back(32'd300);
        send_vector(v, 1'b1, 1'b1, lat);
        wait_idle(tmo);
        n_cmp++; if (tmo || sb.size() != 0) begin n_err++; $display("FAIL ovf_next_vec: tmo=%0b left=%0d, required 0/0", tmo, sb.size()); end
    endtask

    task automatic test_sat_sum;
        logic [31:0] v[$];
        int lat;
        bit tmo;
        v.push_back(32'h8000_0000); v.push_back(32'h8000_0000);
        send_vector(v, 1'b1, 1'b1, lat);
        wait_idle(tmo);
        n_cmp++; if (bus.div_b !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_sum: div_b got %0h, required ffffffff", bus.div_b); end
        n_cmp++; if (tmo || sb.size() != 0) begin n_err++; $display("FAIL sat_drain: tmo=%0b left=%0d, required 0/0", tmo, sb.size()); end
    endtask

    task automatic test_reset_drain;
        logic [31:0] v[$];
        int lat;
        int seen;
        v.push_back(32'd5); v.push_back(32'd9);
        send_vector(v, 1'b1, 1'b0, lat);
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rd_in_drain: in_ready got %0b, required 0", bus.in_ready); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rd_in_ready: got %0b, required 1", bus.in_ready); end
        n_cmp++; if (bus.status_ovf !== 1'b0 || bus.status_div0 !== 1'b0) begin
            n_err++; $display("FAIL rd_status: got ovf=%0b div0=%0b, required 0/0", bus.status_ovf, bus.status_div0);
        end
        seen = 0;
        for (int w = 0; w < 150; w++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rd_no_output: got %0d out_valid cycles, required 0", seen); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_zero_sum();
        test_overflow();
        test_sat_sum();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
